// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type, word alignment mask and an alignment helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is decoded as word too

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo & WORD_ALIGN_MASK) != 2'b00;
    endcase
  endfunction

  // Word and the reserved encoding 2'b11 both move a full word.
  function automatic logic is_word(input logic [1:0] size);
    is_word = (size != SIZE_BYTE) && (size != SIZE_HALF);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit (little-endian).
// load_data: selected lane of rdata, sign- or zero-extended.
// merge_data: rdata with the selected lane replaced by the low bits of wdata
// (for word accesses it is simply wdata). Only DATA_WIDTH = 32 is supported.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  zero_ext,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane extract/extend for loads and lane merge for read-modify-write.
  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    byte_lane  = rdata[{addr_lo, 3'b000} +: 8];
    half_lane  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = rdata;
    case (size)
      SIZE_BYTE: begin
        load_data = zero_ext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = zero_ext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// One request at a time via valid/ready; sub-word stores use read-modify-write;
// misaligned requests return an error without touching memory.
// Optional feature macro: LSU_PERF_CNT_EN adds saturating load/store/error
// response counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]           load_count,
  output logic [15:0]           store_count,
  output logic [15:0]           error_count
`endif
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  unsigned_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] word_q;   // store data, then the merged RMW word
  logic [DATA_WIDTH-1:0] rdata_q;  // extended load result

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  accept;

  assign accept    = (state_q == IDLE) && req_valid;
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .size      (size_q),
    .zero_ext  (unsigned_q),
    .addr_lo   (addr_q[1:0]),
    .rdata     (ReadData),
    .wdata     (word_q),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  // State register and captured request/datapath fields.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, so a dropped operation
    // leaves no stale address, data or error flag behind.
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= SIZE_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        word_q     <= req_wdata;
        err_q      <= is_misaligned(req_size, req_addr[1:0]);
        rdata_q    <= '0;
      end
      if (state_q == LOAD) begin
        rdata_q <= load_data;
      end
      if (state_q == RMW_READ) begin
        word_q <= merge_data;
      end
    end
  end

  // Next-state decode and memory/response outputs for the current state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    WriteData  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) state_d = RESP;
          else if (!req_write)                        state_d = LOAD;
          else if (is_word(req_size))                 state_d = WRITE;
          else                                        state_d = RMW_READ;
        end
      end
      LOAD: begin
        MemRead = 1'b1;
        Address = word_addr;
        state_d = RESP;
      end
      RMW_READ: begin
        MemRead = 1'b1;
        Address = word_addr;
        state_d = WRITE;
      end
      WRITE: begin
        MemWrite  = 1'b1;
        Address   = word_addr;
        WriteData = word_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LSU_PERF_CNT_EN
  // Saturating per-kind response counters, bumped on each resp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      error_count <= '0;
    end else if (state_q == RESP) begin
      if (err_q) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end else if (write_q) begin
        if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      end else begin
        if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory
// model (combinational read, clocked write).
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_count;
  logic [15:0] store_count;
  logic [15:0] error_count;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Memory model plus a backdoor port for preloading words.
  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  assign ReadData = mem[Address[7:2]];

  always @(posedge clk) begin
    if (MemWrite)     mem[Address[7:2]] <= WriteData;
    else if (poke_en) mem[poke_idx]     <= poke_data;
  end

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData)
`ifdef LSU_PERF_CNT_EN
    ,
    .load_count  (load_count),
    .store_count (store_count),
    .error_count (error_count)
`endif
  );

  // Per-cycle observations after a handshake; index k = sampled before edge T+k.
  logic        o_valid [1:4];
  logic        o_err   [1:4];
  logic        o_rd    [1:4];
  logic        o_wr    [1:4];
  logic        o_ready [1:4];
  logic [31:0] o_addr  [1:4];
  logic [31:0] o_wdata [1:4];
  logic [31:0] o_rdata [1:4];
  logic        any_mem;
  logic        any_resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Preload one memory word; starts and ends on a falling edge.
  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic sample(input int k);
    o_valid[k] = resp_valid;
    o_err[k]   = resp_error;
    o_rd[k]    = MemRead;
    o_wr[k]    = MemWrite;
    o_ready[k] = req_ready;
    o_addr[k]  = Address;
    o_wdata[k] = WriteData;
    o_rdata[k] = resp_rdata;
  endtask

  // Issue one request from a falling edge and record four cycles after it.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    check("ready_before_req", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    @(negedge clk);
    poke(6'd4, 32'h80FF_7F01);
    poke(6'd8, 32'h0000_0000);
    poke(6'd12, 32'h0000_0000);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_writedata", WriteData, 32'd0);

    // lb 0x11 from 0x80FF_7F01.
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lb11_memread_t1", 32'(o_rd[1]), 32'd1);
    check("lb11_addr_t1", o_addr[1], 32'h10);
    check("lb11_ready_t1", 32'(o_ready[1]), 32'd0);
    check("lb11_valid_t1", 32'(o_valid[1]), 32'd0);
    check("lb11_valid_t2", 32'(o_valid[2]), 32'd1);
    check("lb11_rdata_t2", o_rdata[2], 32'h0000_007F);
    check("lb11_err_t2", 32'(o_err[2]), 32'd0);
    check("lb11_memread_t2", 32'(o_rd[2]), 32'd0);
    check("lb11_valid_t3", 32'(o_valid[3]), 32'd0);

    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb13_rdata", o_rdata[2], 32'hFFFF_FF80);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu13_rdata", o_rdata[2], 32'h0000_0080);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh12_rdata", o_rdata[2], 32'hFFFF_80FF);
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lhu12_rdata", o_rdata[2], 32'h0000_80FF);

    // sb 0xAB to 0x12 over 0x1122_3344; upper wdata bits must be ignored.
    poke(6'd4, 32'h1122_3344);
    run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAB);
    check("sb_memread_t1", 32'(o_rd[1]), 32'd1);
    check("sb_memwrite_t1", 32'(o_wr[1]), 32'd0);
    check("sb_writedata_t1", o_wdata[1], 32'd0);
    check("sb_memwrite_t2", 32'(o_wr[2]), 32'd1);
    check("sb_memread_t2", 32'(o_rd[2]), 32'd0);
    check("sb_addr_t2", o_addr[2], 32'h10);
    check("sb_writedata_t2", o_wdata[2], 32'h11AB_3344);
    check("sb_valid_t2", 32'(o_valid[2]), 32'd0);
    check("sb_valid_t3", 32'(o_valid[3]), 32'd1);
    check("sb_rdata_t3", o_rdata[3], 32'd0);
    check("sb_mem", mem[4], 32'h11AB_3344);

    // sw then lw at 0x20.
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    check("sw_memwrite_t1", 32'(o_wr[1]), 32'd1);
    check("sw_memread_t1", 32'(o_rd[1]), 32'd0);
    check("sw_addr_t1", o_addr[1], 32'h20);
    check("sw_writedata_t1", o_wdata[1], 32'hDEAD_BEEF);
    check("sw_valid_t2", 32'(o_valid[2]), 32'd1);
    check("sw_memwrite_t2", 32'(o_wr[2]), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("lw20_valid_t2", 32'(o_valid[2]), 32'd1);
    check("lw20_rdata", o_rdata[2], 32'hDEAD_BEEF);

    // sh into the upper half, then a size-11 load (decoded as word).
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_CAFE);
    check("sh22_writedata_t2", o_wdata[2], 32'hCAFE_BEEF);
    check("sh22_valid_t3", 32'(o_valid[3]), 32'd1);
    run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    check("lw11_rdata", o_rdata[2], 32'hCAFE_BEEF);

    // Misaligned lw 0x22 and sh 0x21.
    run_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    any_mem = o_rd[1] | o_rd[2] | o_rd[3] | o_rd[4] | o_wr[1] | o_wr[2] | o_wr[3] | o_wr[4];
    check("lw22_valid_t1", 32'(o_valid[1]), 32'd1);
    check("lw22_err_t1", 32'(o_err[1]), 32'd1);
    check("lw22_rdata_t1", o_rdata[1], 32'd0);
    check("lw22_no_mem", 32'(any_mem), 32'd0);
    check("lw22_valid_t2", 32'(o_valid[2]), 32'd0);
    run_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_5555);
    any_mem = o_rd[1] | o_rd[2] | o_rd[3] | o_rd[4] | o_wr[1] | o_wr[2] | o_wr[3] | o_wr[4];
    check("sh21_valid_t1", 32'(o_valid[1]), 32'd1);
    check("sh21_err_t1", 32'(o_err[1]), 32'd1);
    check("sh21_no_mem", 32'(any_mem), 32'd0);
    check("sh21_mem", mem[8], 32'hCAFE_BEEF);

    // Reset during RMW_READ of an sb: dropped, no write, no response.
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
    end
    any_mem  = o_wr[1] | o_wr[2] | o_wr[3];
    any_resp = o_valid[1] | o_valid[2] | o_valid[3];
    check("rstrmw_ready", 32'(o_ready[1]), 32'd1);
    check("rstrmw_no_write", 32'(any_mem), 32'd0);
    check("rstrmw_no_resp", 32'(any_resp), 32'd0);
    check("rstrmw_mem", mem[4], 32'h11AB_3344);

    // Reset during WRITE of an sw: the write lands, no response.
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
    end
    any_resp = o_valid[1] | o_valid[2] | o_valid[3];
    check("rstwr_mem", mem[12], 32'h1234_5678);
    check("rstwr_no_resp", 32'(any_resp), 32'd0);
    check("rstwr_ready", 32'(o_ready[1]), 32'd1);

    // A misaligned request held on req_valid: accepted only in IDLE cycles.
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h22; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sample(k);
    end
    req_valid = 1'b0;
    check("hold_valid_t1", 32'(o_valid[1]), 32'd1);
    check("hold_ready_t1", 32'(o_ready[1]), 32'd0);
    check("hold_valid_t2", 32'(o_valid[2]), 32'd0);
    check("hold_ready_t2", 32'(o_ready[2]), 32'd1);
    check("hold_valid_t3", 32'(o_valid[3]), 32'd1);
    check("hold_valid_t4", 32'(o_valid[4]), 32'd0);
    @(negedge clk);

`ifdef LSU_PERF_CNT_EN
    check("cnt_load", 32'(load_count), 32'd7);
    check("cnt_store", 32'(store_count), 32'd3);
    check("cnt_error", 32'(error_count), 32'd4);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface; sits between the core's MEM stage and data_memory.
- Accepts one load/store request at a time through a valid/ready handshake and drives MemRead, MemWrite, Address and WriteData.
- Data memory reads combinationally and writes on the clock edge. Byte and halfword stores use read-modify-write (RMW); loads are sign- or zero-extended.
- Misaligned accesses return an error response and never touch memory.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned access, valid with resp_valid.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- Address  out  ADDR_WIDTH  word-aligned byte address, {addr[ADDR_WIDTH-1:2], 2'b00}.
- WriteData  out  DATA_WIDTH  full word to write.
- ReadData  in  DATA_WIDTH  combinational memory read data.

Behaviour:
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Reset value of every output is 0, except req_ready = 1. State returns to IDLE and all captured fields clear.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits 7:0; a half at addr[1] = 1 selects bits 31:16.
- IDLE: req_ready = 1. A handshake (req_valid & req_ready) captures the addr, size, write, unsigned and wdata fields.
- IDLE transitions after a handshake:
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] != 0) -> RESP with error flag set.
  - Load -> LOAD.
  - Word store -> WRITE.
  - Byte or half store -> RMW_READ.
- LOAD: MemRead = 1. Extract the lane from ReadData, sign- or zero-extend it, register the result into resp_rdata, then go to RESP.
- RMW_READ: MemRead = 1. Merge the captured wdata lane into ReadData, register the merged word, then go to WRITE.
- WRITE: MemWrite = 1. WriteData = captured word (word store) or merged word (RMW). Go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response back-pressure.
- req_ready = 0 in every state except IDLE, so no new request is accepted in the RESP cycle.
- MemRead and MemWrite are never both 1. Both are 0 in IDLE and RESP.
- Address and WriteData are 0 whenever their enables are low.
- Latency, counted from the handshake edge T:
  - Load or word store: resp_valid at T+2.
  - Byte/half store: resp_valid at T+3.
  - Error: resp_valid at T+1.
- Reset asserted during WRITE: the memory still samples MemWrite = 1 at that edge, so the write completes. The LSU goes to IDLE with no response.
- Reset in any other non-IDLE state: the operation is dropped with no memory side effect.
- A request held on req_valid while busy is not consumed; it is accepted on the first IDLE cycle.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined, adds three outputs: load_count (16), store_count (16), error_count (16).
- Each counter increments on resp_valid of its kind, saturates at 16'hFFFF, and clears on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - state enum IDLE/LOAD/RMW_READ/WRITE/RESP;
  - WORD_ALIGN_MASK constant.
- One natural sub-module: lsu_lane_align. It is purely combinational and provides:
  - lane extract plus sign/zero extend for loads;
  - lane merge for RMW.
- The FSM stays in load_store_unit.

Test Plan:
- Memory word 0x10 = 0x80FF_7F01. lb at 0x11 -> resp_rdata = 0x0000_007F at T+2. lb at 0x13 -> 0xFFFF_FF80. lbu at 0x13 -> 0x0000_0080.
- Same word. lh at 0x12 -> 0xFFFF_80FF. lhu at 0x12 -> 0x0000_80FF.
- sb 0xAB to 0x12, memory initially 0x1122_3344:
  - MemRead at T+1, MemWrite at T+2 with WriteData = 0x11AB_3344;
  - resp_valid at T+3.
- sw 0xDEAD_BEEF to 0x20: MemWrite only at T+1, Address = 0x20; following lw 0x20 -> 0xDEAD_BEEF.
- lw at 0x22 and sh at 0x21 -> resp_valid with resp_error = 1 at T+1; MemRead and MemWrite stay 0 throughout.
- Reset asserted in the RMW_READ cycle of sb -> no MemWrite, no resp_valid; req_ready = 1 on the next cycle.
